usb_tx_sequencer: RTL and testbench
===================================

# usb_tx_sequencer

Controller that sequences the USB transmit serializer path for one packet. It emits SYNC, then the PID byte, then payload bytes popped from the TX byte FIFO, then EOP. Bits are presented one at a time to the downstream bit stuffer/NRZI encoder, paced by a bit-time tick. The sequencer holds its current bit whenever the bit stuffer stalls to insert a stuffed zero.

## Interface
- MAX_BYTES, 64: maximum payload bytes per packet; reaching it without `byte_last` is an error.
- CNT_W, 7: width of payload byte counter; must satisfy 2**CNT_W > MAX_BYTES.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_start  in  1  single-cycle request to send a packet; honoured only in IDLE
- tx_pid  in  4  PID nibble, latched on accepted `tx_start`
- byte_valid  in  1  FIFO has a payload byte on `byte_data`
- byte_data  in  8  payload byte
- byte_last  in  1  qualifies `byte_data` as final payload byte
- byte_ready  out  1  pop strobe; byte captured on the same edge
- bit_tick  in  1  one-cycle pulse per USB bit time
- stuff_stall  in  1  stuffer inserting a bit; current bit must be held
- tx_bit  out  1  current NRZ data bit, LSB first
- tx_bit_valid  out  1  `tx_bit` meaningful (SYNC, PID, DATA states)
- eop_se0  out  1  drive SE0 on the line
- busy  out  1  packet in progress (any state but IDLE)
- done  out  1  one-cycle pulse on return to IDLE
- tx_error  out  1  one-cycle pulse: FIFO underrun or MAX_BYTES overrun

## Operation
- States: IDLE, SYNC, PID, DATA, EOP_SE0, EOP_J.
- All outputs reset to 0; state resets to IDLE; the shift register, bit counter, and byte counter reset to 0.
- A consume event is `bit_tick & ~stuff_stall` in SYNC/PID/DATA. When `stuff_stall` and `bit_tick` coincide, stall wins and nothing advances.
- 8-bit shift register. `tx_bit` = bit 0. Each consume shifts right and increments the 3-bit bit counter. The counter wraps at 7 and marks the byte boundary.
- IDLE: on `tx_start`, latch PID, load SYNC byte 8'h80, go to SYNC. `tx_start` is ignored in all other states.
- SYNC: at the boundary consume, load {~pid, pid} and go to PID.
- PID: at the boundary consume:
  - `byte_valid`=1: assert `byte_ready`, load `byte_data`, latch `byte_last`, set byte count to 1, go to DATA.
  - `byte_valid`=0: zero-length packet; go to EOP_SE0.
- DATA: at the boundary consume:
  - latched last=1: go to EOP_SE0.
  - else if byte count == MAX_BYTES: pulse `tx_error`, go to EOP_SE0.
  - else if `byte_valid`=1: pop, load the byte, increment the count, stay in DATA.
  - else: underrun; pulse `tx_error`, go to EOP_SE0.
- EOP_SE0: `eop_se0`=1 for 2 bit ticks. `stuff_stall` is ignored.
- EOP_J: `eop_se0`=0 for 1 bit tick. Then pulse `done` and go to IDLE.
- `tx_error` never suppresses EOP; the packet is truncated cleanly.
- `byte_ready` is never asserted outside the PID/DATA boundary consume.

## Timing
- `tx_start` accepted at edge N. At N+1: `busy`=1, `tx_bit_valid`=1, `tx_bit`=0 (SYNC bit 0).
- A bit is held until consumed. The next bit appears on `tx_bit` the cycle after the consuming edge.
- Minimum bit time is 1 clk (`bit_tick` tied high). The design must sustain this rate, including back-to-back byte loads.
- `byte_ready` is combinational, valid in the consume cycle. `byte_data` and `byte_last` are sampled on that edge.
- `done` is high the cycle IDLE is re-entered. `tx_start` is accepted in that same cycle.
- Asynchronous `rst` mid-packet returns to IDLE immediately with all outputs 0. No `done` pulse. No FIFO pop.
- Packet length in bit ticks, excluding stalls: 8·(2+n)+3 for n payload bytes.

## Structure
- Package `usb_tx_pkg`: state enum, SYNC_BYTE = 8'h80, EOP_SE0_TICKS = 2, EOP_J_TICKS = 1.
- Sub-module `tx_bit_cnt`: 3-bit counter with enable, synchronous clear, and rollover flag. It provides the byte boundary and the EOP tick counts.
- The top level holds the FSM, shift register, PID latch, byte counter, and pop/error logic.

## Test plan
- PID 4'h1 (OUT), FIFO empty, `bit_tick` tied high:
  - `tx_bit` sequence is 0,0,0,0,0,0,0,1, then 1,0,0,0,0,1,1,1.
  - Then SE0 for 2 cycles, J for 1 cycle, `done` after 19 ticks.
- PID 4'h3 with payload 8'hA5, 8'h3C (last):
  - exactly 2 `byte_ready` pulses.
  - serial payload 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `tx_error` stays 0.
- `stuff_stall` high on the 7th PID bit for 1 tick: that bit is held one extra tick; the total becomes 20 ticks.
- FIFO goes empty after 1 byte without `byte_last`:
  - `tx_error` pulses at the boundary of byte 1.
  - EOP follows; `done` pulses.
- MAX_BYTES=4 and 6 bytes offered: 4 pops, then a `tx_error` pulse, then EOP.
- `rst` asserted mid-DATA: outputs 0 asynchronously. A new `tx_start` afterwards produces a correct SYNC.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: state encoding and framing constants shared by the USB TX sequencer.
package usb_tx_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP_SE0, EOP_J} state_t;
    localparam logic [7:0] SYNC_BYTE     = 8'h80;
    localparam logic [2:0] EOP_SE0_TICKS = 3'd2;
    localparam logic [2:0] EOP_J_TICKS   = 3'd1;
endpackage

// File: rtl/tx_bit_cnt.sv
// tx_bit_cnt: 3-bit bit-time counter; wrap marks the last bit of a byte.
module tx_bit_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] cnt,
    output logic       wrap
);
    assign wrap = cnt == 3'd7;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 3'd1;
endmodule

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: serialises SYNC, PID, FIFO payload and EOP for one USB packet.
module usb_tx_sequencer import usb_tx_pkg::*; #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       bit_tick,
    input  logic       stuff_stall,
    output logic       tx_bit,
    output logic       tx_bit_valid,
    output logic       eop_se0,
    output logic       busy,
    output logic       done,
    output logic       tx_error
);
    state_t state;
    logic [7:0] shreg;
    logic [3:0] pid_q;
    logic last_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [2:0] bit_cnt;
    logic wrap, in_bits, in_eop, consume, boundary, eop_end, at_max;
    assign in_bits = state inside {SYNC, PID, DATA};
    assign in_eop = state inside {EOP_SE0, EOP_J};
    assign consume = in_bits & bit_tick & ~stuff_stall;
    assign boundary = consume & wrap;
    // EOP phases reuse the bit counter; the stuffer stall does not apply there
    assign eop_end = in_eop & bit_tick & (bit_cnt == ((state == EOP_SE0) ? EOP_SE0_TICKS : EOP_J_TICKS) - 3'd1);
    assign at_max = byte_cnt == CNT_W'(MAX_BYTES);
    assign byte_ready = boundary & byte_valid & ((state == PID) | ((state == DATA) & ~last_q & ~at_max));
    assign tx_bit = shreg[0];
    assign tx_bit_valid = in_bits;
    assign eop_se0 = state == EOP_SE0;
    assign busy = state != IDLE;
    tx_bit_cnt u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (consume | (in_eop & bit_tick)),
        .clr (eop_end),
        .cnt (bit_cnt),
        .wrap(wrap)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            pid_q    <= '0;
            last_q   <= 1'b0;
            byte_cnt <= '0;
            done     <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            done     <= 1'b0;
            tx_error <= 1'b0;
            if (consume) shreg <= {1'b0, shreg[7:1]};
            case (state)
                IDLE: if (tx_start) begin
                    pid_q    <= tx_pid;
                    shreg    <= SYNC_BYTE;
                    byte_cnt <= '0;
                    last_q   <= 1'b0;
                    state    <= SYNC;
                end
                SYNC: if (boundary) begin
                    shreg <= {~pid_q, pid_q};
                    state <= PID;
                end
                PID: if (boundary) begin
                    if (byte_valid) begin
                        shreg    <= byte_data;
                        last_q   <= byte_last;
                        byte_cnt <= CNT_W'(1);
                        state    <= DATA;
                    end else state <= EOP_SE0;
                end
                DATA: if (boundary) begin
                    if (byte_ready) begin
                        shreg    <= byte_data;
                        last_q   <= byte_last;
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end else begin
                        tx_error <= ~last_q;
                        state    <= EOP_SE0;
                    end
                end
                EOP_SE0: if (eop_end) state <= EOP_J;
                EOP_J: if (eop_end) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb_usb_tx_sequencer: directed and randomized packets checked against a packet-level model.
module tb_usb_tx_sequencer;
    localparam int MAX = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic tx_start, byte_valid, byte_last, byte_ready, bit_tick, stuff_stall;
    logic tx_bit, tx_bit_valid, eop_se0, busy, done, tx_error;
    logic [3:0] tx_pid;
    logic [7:0] byte_data;
    int n_cmp = 0, n_err = 0, last_raw = 0;
    logic [7:0] fifo_d[$];
    logic fifo_l[$];
    always #5 clk = ~clk;
    usb_tx_sequencer #(.MAX_BYTES(MAX), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .bit_tick(bit_tick), .stuff_stall(stuff_stall),
        .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .eop_se0(eop_se0),
        .busy(busy), .done(done), .tx_error(tx_error)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic refresh();
        byte_valid = fifo_d.size() > 0;
        byte_data = 8'h00;
        byte_last = 1'b0;
        if (byte_valid) begin
            byte_data = fifo_d[0];
            byte_last = fifo_l[0];
        end
    endtask
    task automatic load(input int len, input int last_idx);
        fifo_d.delete();
        fifo_l.delete();
        for (int i = 0; i < len; i++) begin
            fifo_d.push_back(8'($urandom));
            fifo_l.push_back(i == last_idx);
        end
        refresh();
    endtask
    // mode 0: tick every clock; 1: random ticks and stalls; 2: one stall on the 7th PID bit
    task automatic run_packet(input logic [3:0] pid, input int mode);
        logic [7:0] offer_d[$] = fifo_d;
        logic offer_l[$] = fifo_l;
        logic [63:0] exp_vec = '0, obs_vec = '0;
        logic [7:0] pb;
        logic err = 1'b0, fin = 1'b0, got_done = 1'b0, was_pop, stalled = 1'b0;
        int n = 0, exp_len, obs_n = 0, pops = 0, errs = 0, errs_eop = 0;
        int se0 = 0, jt = 0, stalls = 0, raw = 0, cyc = 0;
        for (int i = 0; i < offer_d.size() && !fin && !err; i++) begin
            if (n == MAX) err = 1'b1;
            else begin
                n++;
                fin = offer_l[i];
            end
        end
        if (n > 0 && !fin) err = 1'b1;
        exp_vec[7] = 1'b1;
        pb = {~pid, pid};
        for (int b = 0; b < 8; b++) exp_vec[8 + b] = pb[b];
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) exp_vec[16 + 8 * i + b] = offer_d[i][b];
        exp_len = 16 + 8 * n;
        tx_pid = pid;
        tx_start = 1'b1;
        bit_tick = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
        stuff_stall = (mode == 1) ? ($urandom_range(5) == 0) : 1'b0;
        @(posedge clk);
        #1 tx_start = 1'b0;
        check("start_sync_bit0", 64'({busy, tx_bit_valid, tx_bit}), 64'(3'b110));
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (tx_bit_valid && bit_tick && !stuff_stall) begin
                if (obs_n < 64) obs_vec[obs_n] = tx_bit;
                obs_n++;
            end
            if (tx_bit_valid && bit_tick && stuff_stall) stalls++;
            if (busy && bit_tick) raw++;
            if (eop_se0 && bit_tick) se0++;
            if (busy && !tx_bit_valid && !eop_se0 && bit_tick) jt++;
            if (byte_ready) pops++;
            if (tx_error) begin
                errs++;
                if (eop_se0) errs_eop++;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            was_pop = byte_ready;
            @(posedge clk);
            #1;
            if (was_pop && fifo_d.size() > 0) begin
                void'(fifo_d.pop_front());
                void'(fifo_l.pop_front());
            end
            refresh();
            bit_tick = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            stuff_stall = (mode == 1) ? ($urandom_range(5) == 0) : (mode == 2 && obs_n == 14 && !stalled);
            if (mode == 2 && stuff_stall) stalled = 1'b1;
        end
        last_raw = raw;
        check("done_seen", 64'(got_done), 64'(1));
        check("bit_count", 64'(obs_n), 64'(exp_len));
        check("bit_stream", obs_vec, exp_vec);
        check("pops", 64'(pops), 64'(n));
        check("tx_error", 64'(errs), 64'(err));
        check("tx_error_at_eop", 64'(errs_eop), 64'(err));
        check("ticks", 64'(raw - stalls), 64'(8 * (2 + n) + 3));
        check("se0_ticks", 64'(se0), 64'(2));
        check("j_ticks", 64'(jt), 64'(1));
    endtask
    initial begin
        int len, li;
        tx_start = 1'b0;
        tx_pid = 4'h0;
        bit_tick = 1'b0;
        stuff_stall = 1'b0;
        load(0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({byte_ready, tx_bit, tx_bit_valid, eop_se0, busy, done, tx_error}), 64'(0));
        rst = 1'b0;
        bit_tick = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start", 64'({busy, tx_bit_valid, done}), 64'(0));
        run_packet(4'h1, 0);
        check("out_empty_19", 64'(last_raw), 64'(19));
        fifo_d = '{8'hA5, 8'h3C};
        fifo_l = '{1'b0, 1'b1};
        refresh();
        run_packet(4'h3, 0);
        load(0, -1);
        run_packet(4'h1, 2);
        check("stall_20", 64'(last_raw), 64'(20));
        load(1, -1);
        run_packet(4'h9, 0);
        load(6, -1);
        run_packet(4'h2, 0);
        load(4, 3);
        run_packet(4'hB, 1);
        load(3, 2);
        tx_pid = 4'h5;
        tx_start = 1'b1;
        bit_tick = 1'b1;
        stuff_stall = 1'b0;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_data", 64'({busy, tx_bit_valid, eop_se0}), 64'(3'b110));
        rst = 1'b1;
        #1;
        check("rst_async", 64'({byte_ready, tx_bit, tx_bit_valid, eop_se0, busy, done, tx_error}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        load(0, -1);
        @(posedge clk);
        #1;
        check("rst_no_done", 64'({done, busy, tx_error}), 64'(0));
        load(2, 1);
        run_packet(4'h5, 0);
        for (int k = 0; k < 12; k++) begin
            len = int'($urandom_range(6));
            li = int'($urandom_range(7)) - 1;
            load(len, li);
            run_packet(4'($urandom_range(15)), int'($urandom_range(1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
